// File: rtl/vga_tile_scan.sv
// VGA raster timing generator and tile scanner: each (2**TILE_SHIFT)^2 pixel tile shows one video-RAM byte as RRGGBB.
// Optional cell-border overlay is compiled in only when VGA_GRID_EN is defined.
module vga_tile_scan #(
    parameter int COLOR_BITS = 8,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int TILE_SHIFT = 5,
    parameter int TILES_X    = 20,
    parameter int ADDR_W     = 9,
    parameter int MEM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    output logic [ADDR_W-1:0]     vaddr,
    input  logic [31:0]           vdata,
    output logic [COLOR_BITS-1:0] VGA_R,
    output logic [COLOR_BITS-1:0] VGA_G,
    output logic [COLOR_BITS-1:0] VGA_B,
    output logic                  VGA_HS_O,
    output logic                  VGA_VS_O,
    output logic                  frame_start,
    output logic                  vblank
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);
    localparam int TW      = XW + YW;

    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_FIRST = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_LAST  = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_FIRST = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_LAST  = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Per-pixel attributes that travel alongside the RAM read; sync flags are stored active-high.
    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       vb;
        logic [1:0] lane;
`ifdef VGA_GRID_EN
        logic       grid;
`endif
    } tap_t;

    function automatic logic [COLOR_BITS-1:0] rep2(input logic [1:0] v);
        for (int i = 0; i < COLOR_BITS; i++)
            rep2[i] = ((COLOR_BITS - 1 - i) % 2 == 0) ? v[1] : v[0];
    endfunction

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [TW-1:0] tile;
    tap_t          tap_d, tap_l;
    tap_t          pipe_q [MEM_LAT];

    // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        x_d = x_q + 1'b1;
        y_d = y_q;
        if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end
    end

    // Row base is TILES_X * tile_row built from the set bits of TILES_X (constant shift-add).
    always_comb begin
        tile = TW'(x_q >> TILE_SHIFT);
        for (int i = 0; i < 32; i++)
            if (TILES_X[i]) tile = tile + (TW'(y_q >> TILE_SHIFT) << i);
    end

    assign vaddr = tile[ADDR_W-1:0];

    always_comb begin
        tap_d.de   = (x_q < X_ACT) && (y_q < Y_ACT);
        tap_d.hs   = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
        tap_d.vs   = (y_q >= VS_FIRST) && (y_q <= VS_LAST);
        tap_d.fs   = (x_q == '0) && (y_q == '0);
        tap_d.vb   = (y_q >= Y_ACT);
        tap_d.lane = tile[1:0];
`ifdef VGA_GRID_EN
        tap_d.grid = (x_q[TILE_SHIFT-1:0] == '0) || (y_q[TILE_SHIFT-1:0] == '0);
`endif
    end

    // NOTE: the delay line is only MEM_LAT small words, so it is reset to "inactive" so that
    // no stale sync or colour reaches the pins during the first L clocks after release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q <= '0;
            y_q <= '0;
            for (int i = 0; i < MEM_LAT; i++) pipe_q[i] <= '0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            pipe_q[0] <= tap_d;
            for (int i = 1; i < MEM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign tap_l = pipe_q[MEM_LAT-1];

    logic [7:0]            byte_sel;
    logic [COLOR_BITS-1:0] r_d, g_d, b_d;

    always_comb begin
        byte_sel = vdata[31:24];
        case (tap_l.lane)
            2'd1:    byte_sel = vdata[23:16];
            2'd2:    byte_sel = vdata[15:8];
            2'd3:    byte_sel = vdata[7:0];
            default: byte_sel = vdata[31:24];
        endcase
    end

    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (tap_l.de) begin
            r_d = rep2(byte_sel[5:4]);
            g_d = rep2(byte_sel[3:2]);
            b_d = rep2(byte_sel[1:0]);
`ifdef VGA_GRID_EN
            if (tap_l.grid) begin
                r_d = rep2(2'b01);
                g_d = rep2(2'b01);
                b_d = rep2(2'b01);
            end
`endif
        end
    end

    logic unused_bits;
    assign unused_bits = ^{byte_sel[7:6], tile[TW-1:ADDR_W]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS_O    <= ~HS_POL;
            VGA_VS_O    <= ~VS_POL;
            frame_start <= 1'b0;
            vblank      <= 1'b0;
        end else begin
            VGA_R       <= r_d;
            VGA_G       <= g_d;
            VGA_B       <= b_d;
            VGA_HS_O    <= tap_l.hs ? HS_POL : ~HS_POL;
            VGA_VS_O    <= tap_l.vs ? VS_POL : ~VS_POL;
            frame_start <= tap_l.fs;
            vblank      <= tap_l.vb;
        end
    end
endmodule
